cpu_log_checker: RTL and testbench

- Streaming checker that consumes one ASCII character per accepted cycle from a CPU trace log.
- Decides whether each line matches the register-write format or the memory-write format.
- Sits downstream of the ASCII-to-digit stage; uses its digit value (char - 8'h30) to accumulate the decimal time field.
- Reports line type, parsed time and a running count of valid lines to the comparison logic.

---
 rtl/cpu_log_checker.sv | 127 ++++++++++++
 tb/tb_cpu_log_checker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cpu_log_checker.sv
// Streaming checker for CPU trace log lines: classifies each line as a register
// write or memory write, captures its decimal time field and counts valid lines.
module cpu_log_checker #(
  parameter int MAX_DEC = 4,
  parameter int HEX_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char,
  output logic [1:0]  format_type,
  output logic [15:0] line_time,
  output logic [7:0]  line_count
);

  localparam int CNT_MAX = (HEX_LEN > MAX_DEC) ? HEX_LEN : MAX_DEC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEC_LIM = CW'(MAX_DEC);
  localparam logic [CW-1:0] HEX_LIM = CW'(HEX_LEN);

  typedef enum logic [3:0] {
    IDLE, TIME, PC, COLON, SP1, GRF, ADDR, SP2, EQ, SP3, DATA, END_REG, END_MEM
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   acc_q;
  logic          mem_q;
  logic [1:0]    fmt_q;
  logic [15:0]   time_q;
  logic [7:0]    count_q;

  logic          is_dec, is_hex, is_sp;
  logic [15:0]   acc_d;
  logic [CW-1:0] cnt_d;

  assign is_dec = (char >= 8'h30) && (char <= 8'h39);
  assign is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
  assign is_sp  = (char == 8'h20);
  assign acc_d  = 16'(acc_q * 16'd10) + {8'h00, char - 8'h30};
  assign cnt_d  = cnt_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mem_q   <= 1'b0;
      fmt_q   <= 2'b00;
      time_q  <= '0;
      count_q <= '0;
    end else if (char_valid) begin
      fmt_q <= 2'b00;
      if (char == "^") begin
        state_q <= TIME;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          TIME:
            if (is_dec && cnt_q < DEC_LIM) begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
            end else if (char == "@" && cnt_q != '0) begin
              state_q <= PC;
              cnt_q   <= '0;
            end else state_q <= IDLE;
          PC:
            if (is_hex && cnt_q < HEX_LIM) cnt_q <= cnt_d;
            else if (char == ":" && cnt_q == HEX_LIM) state_q <= COLON;
            else state_q <= IDLE;
          COLON, SP1:
            if (is_sp) state_q <= SP1;
            else if (char == "$") begin
              state_q <= GRF;
              cnt_q   <= '0;
              mem_q   <= 1'b0;
            end else if (char == "*") begin
              state_q <= ADDR;
              cnt_q   <= '0;
              mem_q   <= 1'b1;
            end else state_q <= IDLE;
          // Spaces between '$' and the register number are tolerated ("$ 1").
          GRF:
            if (is_dec && cnt_q < DEC_LIM) cnt_q <= cnt_d;
            else if (is_sp && cnt_q == '0) state_q <= GRF;
            else if (is_sp) state_q <= SP2;
            else if (char == "<" && cnt_q != '0) state_q <= EQ;
            else state_q <= IDLE;
          ADDR:
            if (is_hex && cnt_q < HEX_LIM) cnt_q <= cnt_d;
            else if (is_sp && cnt_q == HEX_LIM) state_q <= SP2;
            else if (char == "<" && cnt_q == HEX_LIM) state_q <= EQ;
            else state_q <= IDLE;
          SP2:
            if (is_sp) state_q <= SP2;
            else if (char == "<") state_q <= EQ;
            else state_q <= IDLE;
          EQ:
            if (char == "=") state_q <= SP3;
            else state_q <= IDLE;
          SP3:
            if (is_sp) state_q <= SP3;
            else if (is_hex) begin
              state_q <= DATA;
              cnt_q   <= CW'(1);
            end else state_q <= IDLE;
          DATA:
            if (is_hex && cnt_q < HEX_LIM) cnt_q <= cnt_d;
            else if (char == "#" && cnt_q == HEX_LIM) begin
              state_q <= mem_q ? END_MEM : END_REG;
              fmt_q   <= mem_q ? 2'b10 : 2'b01;
              time_q  <= acc_q;
              if (count_q != 8'hFF) count_q <= count_q + 8'd1;
            end else state_q <= IDLE;
          default:
            state_q <= IDLE;
        endcase
      end
    end
  end

  assign format_type = fmt_q;
  assign line_time   = time_q;
  assign line_count  = count_q;

endmodule

// File: tb/tb_cpu_log_checker.sv
// Scoreboard bench for cpu_log_checker: stimulus queues expected line results,
// a monitor pops and compares them whenever a line result appears.
module tb_cpu_log_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_valid;
  logic [7:0]  char;
  logic [1:0]  format_type;
  logic [15:0] line_time;
  logic [7:0]  line_count;

  typedef struct {
    logic [1:0] fmt;
    int         tm;
    int         cnt;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  cpu_log_checker #(.MAX_DEC(4), .HEX_LEN(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char       (char),
    .format_type(format_type),
    .line_time  (line_time),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] f, input int t, input int c);
    exp_t e;
    e.fmt = f;
    e.tm  = t;
    e.cnt = c;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    char_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] c);
    char       = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic send(input string s, input int gap_max);
    for (int i = 0; i < s.len(); i++) begin
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
      put(s[i]);
    end
  endtask

  // Monitor: a line result is presented when format_type turns non-zero.
  initial begin
    logic prev_act;
    exp_t e;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (format_type != 2'b00 && !prev_act) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_line: got fmt=%0d time=%0d count=%0d expected none",
                   format_type, line_time, line_count);
        end else begin
          e = sbq.pop_front();
          chk("fmt", int'(format_type), int'(e.fmt));
          chk("time", int'(line_time), e.tm);
          chk("count", int'(line_count), e.cnt);
        end
      end
      prev_act = (format_type != 2'b00);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    string bad[6];
    reset      = 1'b1;
    char_valid = 1'b0;
    char       = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_fmt", int'(format_type), 0);
    chk("reset_time", int'(line_time), 0);
    chk("reset_count", int'(line_count), 0);

    push(2'b01, 10, 1);
    send("^10@00003000: $ 1 <= 0000000a#", 0);
    push(2'b10, 9999, 2);
    send("^9999@00003004: *00000010 <= ffffffff#", 0);
    chk("mem_fmt_held", int'(format_type), 2);

    bad[0] = "^12345@00003000: $1 <= 00000000#";
    bad[1] = "^1@0000300: $1 <= 00000000#";
    bad[2] = "^1@0000300A: $1 <= 00000000#";
    bad[3] = "^1@00003000: $1 < = 00000001#";
    bad[4] = "^1@00003000: $12345 <= 00000000#";
    bad[5] = "^1@00003000: *0000001 <= 0000000#";
    for (int i = 0; i < 6; i++) begin
      send(bad[i], 0);
      chk($sformatf("bad%0d_fmt", i), int'(format_type), 0);
      chk($sformatf("bad%0d_count", i), int'(line_count), 2);
      chk($sformatf("bad%0d_time", i), int'(line_time), 9999);
    end

    push(2'b01, 42, 3);
    send("^42@0000abcd:$3<=12345678#", 2);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("gap_hold_fmt", int'(format_type), 1);
    end

    send("^5@000", 0);
    push(2'b01, 7, 4);
    send("^7@00003000: $2 <= 00000001#", 0);

    send("^3@0000", 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_fmt", int'(format_type), 0);
    chk("async_rst_time", int'(line_time), 0);
    chk("async_rst_count", int'(line_count), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) begin
      push(2'b01, i % 1000, (i + 1 > 255) ? 255 : i + 1);
      send($sformatf("^%0d@00000000:$1<=00000000#", i % 1000), 0);
    end
    idle(3);
    chk("sat_count", int'(line_count), 255);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
